// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file with registered read ports, optional
// write-first forwarding, optional hard-wired zero entry and a sticky range error flag.

module register_file_2r1w_rd #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
    input  logic                         re,
    input  logic [AW-1:0]                raddr,
    input  logic                         write_hit,
    input  logic [AW-1:0]                waddr,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         rvalid,
    output logic                         range_err
);
    logic             in_range;
    logic [WIDTH-1:0] rd_next;

    assign in_range  = 32'(raddr) < DEPTH;
    assign range_err = re && !in_range;

    // write_hit already excludes clear, out-of-range and zero-register writes,
    // so forwarding never exposes data that will not land in storage.
    always_comb begin
        rd_next = '0;
        if (!in_range || (ZERO_REG != 0 && raddr == '0))
            rd_next = '0;
        else if (BYPASS != 0 && write_hit && waddr == raddr)
            rd_next = wdata;
        else
            rd_next = mem[raddr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re)
                rdata <= rd_next;
        end
    end
endmodule

module register_file_2r1w #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic             addr_err
);
    localparam int NUM_PORTS = 2;

    logic [DEPTH-1:0][WIDTH-1:0]     mem;
    logic                            waddr_ok;
    logic                            write_hit;
    logic [NUM_PORTS-1:0]            re;
    logic [NUM_PORTS-1:0][AW-1:0]    raddr;
    logic [NUM_PORTS-1:0][WIDTH-1:0] rdata;
    logic [NUM_PORTS-1:0]            rvalid;
    logic [NUM_PORTS-1:0]            rd_err;

    assign waddr_ok  = 32'(waddr) < DEPTH;
    assign write_hit = we && !clear && waddr_ok && !(ZERO_REG != 0 && waddr == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mem <= '0;
        else if (clear)
            mem <= '0;
        else if (write_hit)
            mem[waddr] <= wdata;
    end

    assign re    = {re_b, re_a};
    assign raddr = {raddr_b, raddr_a};

    genvar p;
    for (p = 0; p < NUM_PORTS; p++) begin : g_rd
        register_file_2r1w_rd #(
            .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .clk       (clk),
            .reset     (reset),
            .mem       (mem),
            .re        (re[p]),
            .raddr     (raddr[p]),
            .write_hit (write_hit),
            .waddr     (waddr),
            .wdata     (wdata),
            .rdata     (rdata[p]),
            .rvalid    (rvalid[p]),
            .range_err (rd_err[p])
        );
    end

    assign rdata_a  = rdata[0];
    assign rdata_b  = rdata[1];
    assign rvalid_a = rvalid[0];
    assign rvalid_b = rvalid[1];

    // Clear wins over a same-edge range violation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            addr_err <= 1'b0;
        else if (clear)
            addr_err <= 1'b0;
        else if ((we && !waddr_ok) || (|rd_err))
            addr_err <= 1'b1;
    end
endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: a DEPTH=6 forwarding instance driven from a vector
// table, and a DEPTH=8 read-first zero-register instance driven by hand sequences.

module tb_register_file_2r1w;
    typedef struct packed {
        logic        clear;
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        re_a;
        logic [2:0]  raddr_a;
        logic        re_b;
        logic [2:0]  raddr_b;
    } in_t;

    typedef struct packed {
        logic        rva;
        logic [15:0] rda;
        logic        rvb;
        logic [15:0] rdb;
        logic        err;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk;
    logic reset;
    in_t  in0, in1;
    out_t out0, out1;
    out_t q0[$];
    out_t q1[$];
    int   checks = 0;
    int   fails  = 0;
    int   n0 = 0;
    int   n1 = 0;
    vec_t tbl[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    register_file_2r1w #(.WIDTH(16), .DEPTH(6), .AW(3), .ZERO_REG(0), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .clear(in0.clear), .we(in0.we), .waddr(in0.waddr),
        .wdata(in0.wdata), .re_a(in0.re_a), .re_b(in0.re_b), .raddr_a(in0.raddr_a),
        .raddr_b(in0.raddr_b), .rdata_a(out0.rda), .rdata_b(out0.rdb),
        .rvalid_a(out0.rva), .rvalid_b(out0.rvb), .addr_err(out0.err)
    );

    register_file_2r1w #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .clear(in1.clear), .we(in1.we), .waddr(in1.waddr),
        .wdata(in1.wdata), .re_a(in1.re_a), .re_b(in1.re_b), .raddr_a(in1.raddr_a),
        .raddr_b(in1.raddr_b), .rdata_a(out1.rda), .rdata_b(out1.rdb),
        .rvalid_a(out1.rva), .rvalid_b(out1.rvb), .addr_err(out1.err)
    );

    function automatic in_t vi(logic c, logic w, logic [2:0] wa, logic [15:0] wd,
                               logic ra, logic [2:0] aa, logic rb, logic [2:0] ab);
        in_t r;
        r = '{clear: c, we: w, waddr: wa, wdata: wd, re_a: ra, raddr_a: aa, re_b: rb, raddr_b: ab};
        return r;
    endfunction

    function automatic out_t vo(logic va, logic [15:0] da, logic vb, logic [15:0] db, logic e);
        out_t r;
        r = '{rva: va, rda: da, rvb: vb, rdb: db, err: e};
        return r;
    endfunction

    task automatic cmp(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got rva=%b rda=%h rvb=%b rdb=%h err=%b, expected rva=%b rda=%h rvb=%b rdb=%h err=%b",
                     name, act.rva, act.rda, act.rvb, act.rdb, act.err,
                     exp.rva, exp.rda, exp.rvb, exp.rdb, exp.err);
        end
    endtask

    task automatic drive0(input in_t i, input out_t o);
        in0 = i;
        q0.push_back(o);
    endtask

    task automatic drive1(input in_t i, input out_t o);
        in1 = i;
        q1.push_back(o);
    endtask

    // One clock: outputs of the edge are compared against whatever was queued
    // when the stimulus for that edge was driven.
    task automatic step();
        out_t e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp($sformatf("u0 cycle %0d", n0), out0, e);
            n0++;
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp($sformatf("u1 cycle %0d", n1), out1, e);
            n1++;
        end
    endtask

    initial begin
        tbl[0]  = '{vi(0,0,0,16'h0000,1,2,1,5), vo(1,16'h0000,1,16'h0000,0)};
        tbl[1]  = '{vi(0,1,3,16'hBEEF,0,0,0,0), vo(0,16'h0000,0,16'h0000,0)};
        tbl[2]  = '{vi(0,0,0,16'h0000,1,3,0,0), vo(1,16'hBEEF,0,16'h0000,0)};
        tbl[3]  = '{vi(0,1,5,16'h1111,0,0,0,0), vo(0,16'hBEEF,0,16'h0000,0)};
        tbl[4]  = '{vi(0,1,5,16'h2222,1,5,1,5), vo(1,16'h2222,1,16'h2222,0)};
        tbl[5]  = '{vi(0,0,0,16'h0000,1,5,1,3), vo(1,16'h2222,1,16'hBEEF,0)};
        tbl[6]  = '{vi(0,1,0,16'hFFFF,0,0,1,0), vo(0,16'h2222,1,16'hFFFF,0)};
        tbl[7]  = '{vi(0,1,7,16'hDEAD,0,0,0,0), vo(0,16'h2222,0,16'hFFFF,1)};
        tbl[8]  = '{vi(0,0,0,16'h0000,1,7,1,0), vo(1,16'h0000,1,16'hFFFF,1)};
        tbl[9]  = '{vi(0,0,0,16'h0000,1,5,1,3), vo(1,16'h2222,1,16'hBEEF,1)};
        tbl[10] = '{vi(0,0,0,16'h0000,1,6,0,0), vo(1,16'h0000,0,16'hBEEF,1)};
        tbl[11] = '{vi(1,1,2,16'hABCD,1,3,1,2), vo(1,16'hBEEF,1,16'h0000,0)};
        tbl[12] = '{vi(0,0,0,16'h0000,1,2,1,3), vo(1,16'h0000,1,16'h0000,0)};
        tbl[13] = '{vi(0,1,4,16'h00A5,1,4,0,0), vo(1,16'h00A5,0,16'h0000,0)};
        tbl[14] = '{vi(0,0,0,16'h0000,0,0,1,6), vo(0,16'h00A5,1,16'h0000,1)};
        tbl[15] = '{vi(1,0,0,16'h0000,1,4,0,0), vo(1,16'h00A5,0,16'h0000,0)};

        reset = 1'b0;
        in0 = '0;
        in1 = '0;
        #3;
        cmp("u0 reset state", out0, vo(0,16'h0000,0,16'h0000,0));
        cmp("u1 reset state", out1, vo(0,16'h0000,0,16'h0000,0));
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 16; k++) begin
            drive0(tbl[k].i, tbl[k].o);
            step();
        end
        in0 = '0;

        // Read-first collision, then re-read; zero register ignores writes.
        drive1(vi(0,1,5,16'h1111,0,0,0,0), vo(0,16'h0000,0,16'h0000,0)); step();
        drive1(vi(0,1,5,16'h2222,1,5,1,5), vo(1,16'h1111,1,16'h1111,0)); step();
        drive1(vi(0,0,0,16'h0000,1,5,0,0), vo(1,16'h2222,0,16'h1111,0)); step();
        drive1(vi(0,1,0,16'hFFFF,0,0,1,0), vo(0,16'h2222,1,16'h0000,0)); step();
        drive1(vi(0,0,0,16'h0000,1,0,0,0), vo(1,16'h0000,0,16'h0000,0)); step();
        drive1(vi(0,0,0,16'h0000,1,7,1,5), vo(1,16'h0000,1,16'h2222,0)); step();
        in1 = '0;

        // Asynchronous reset mid-cycle with a write and a read pending.
        drive0(vi(0,1,1,16'h1234,0,0,0,0), vo(0,16'h00A5,0,16'h0000,0)); step();
        drive0(vi(0,1,7,16'h5A5A,1,1,0,0), vo(1,16'h1234,0,16'h0000,1)); step();
        in0 = vi(0,1,2,16'h5555,1,2,0,0);
        #2;
        reset = 1'b0;
        #1;
        cmp("u0 async reset", out0, vo(0,16'h0000,0,16'h0000,0));
        in0 = '0;
        @(negedge clk);
        reset = 1'b1;
        drive0(vi(0,0,0,16'h0000,1,1,1,2), vo(1,16'h0000,1,16'h0000,0)); step();
        drive0(vi(0,0,0,16'h0000,1,3,1,5), vo(1,16'h0000,1,16'h0000,0)); step();
        in0 = '0;

        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
